mult_issue_queue: RTL and testbench

//  Upstream feeder and result collector for the sequential Booth multiplier.
//  - Buffers operand pairs from a valid/ready source in a small FIFO.
//  - Issues one operation at a time: a single-cycle start pulse with held operands.
//  - Waits for the multiplier's done pulse, with a timeout watchdog.
//  - Returns each tagged product on a valid/ready result port, in issue order.

---
 rtl/mult_pkg.sv | 16 +
 rtl/mult_op_fifo.sv | 59 +++++
 rtl/mult_issue_queue.sv | 160 ++++++++++++++++
 tb/tb_mult_issue_queue.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and helpers for the Booth multiplier issue queue.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } mult_iss_state_e;

    // Timer must be able to hold the value TIMEOUT itself.
    function automatic int timer_width(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mult_op_fifo.sv
// Small synchronous FIFO for operand entries; head is readable combinationally
// so the issue FSM can load it in the same cycle it pops.
module mult_op_fifo #(
    parameter int DW    = 18,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [DW-1:0]                push_data,
    input  logic                         pop,
    output logic [DW-1:0]                pop_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/mult_issue_queue.sv
// Feeds buffered operand pairs to a sequential multiplier one at a time and
// returns tagged products (or timeout errors) in issue order.
module mult_issue_queue
    import mult_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 2,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 mult_start,
    output logic [WIDTH-1:0]     mult_a,
    output logic [WIDTH-1:0]     mult_b,
    input  logic [2*WIDTH-1:0]   mult_product,
    input  logic                 mult_done,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_product,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 out_err,
    output logic                 busy
);

    localparam int TW = timer_width(TIMEOUT);
    localparam int DW = TAG_W + 2 * WIDTH;
    localparam int CW = $clog2(DEPTH + 1);

    mult_iss_state_e      state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d, timer_next;
    logic [WIDTH-1:0]     a_q, a_d, b_q, b_d;
    logic [TAG_W-1:0]     tag_q, tag_d;
    logic                 out_valid_q, out_valid_d;
    logic [2*WIDTH-1:0]   out_product_q, out_product_d;
    logic [TAG_W-1:0]     out_tag_q, out_tag_d;
    logic                 out_err_q, out_err_d;

    logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DW-1:0]        fifo_rdata;
    logic [CW-1:0]        fifo_count;

    // Ready comes only from the registered occupancy and is forced low in reset.
    assign in_ready  = rst_n && !fifo_full;
    assign fifo_push = in_valid && in_ready;

    mult_op_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data ({in_tag, in_b, in_a}),
        .pop       (fifo_pop),
        .pop_data  (fifo_rdata),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Timer counts WAIT cycles including the current one.
    assign timer_next = timer_q + TW'(1);

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        a_d           = a_q;
        b_d           = b_q;
        tag_d         = tag_q;
        out_valid_d   = out_valid_q;
        out_product_d = out_product_q;
        out_tag_d     = out_tag_q;
        out_err_d     = out_err_q;
        fifo_pop      = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop            = 1'b1;
                    {tag_d, b_d, a_d}   = fifo_rdata;
                    state_d             = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                timer_d = timer_next;
                // A done arriving on the expiry cycle still counts as success.
                if (mult_done) begin
                    out_product_d = mult_product;
                    out_err_d     = 1'b0;
                    out_tag_d     = tag_q;
                    out_valid_d   = 1'b1;
                    state_d       = RESP;
                end else if (timer_next == TW'(TIMEOUT)) begin
                    out_product_d = '0;
                    out_err_d     = 1'b1;
                    out_tag_d     = tag_q;
                    out_valid_d   = 1'b1;
                    state_d       = RESP;
                end
            end
            RESP: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        fifo_pop          = 1'b1;
                        {tag_d, b_d, a_d} = fifo_rdata;
                        state_d           = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            timer_q       <= '0;
            a_q           <= '0;
            b_q           <= '0;
            tag_q         <= '0;
            out_valid_q   <= 1'b0;
            out_product_q <= '0;
            out_tag_q     <= '0;
            out_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            a_q           <= a_d;
            b_q           <= b_d;
            tag_q         <= tag_d;
            out_valid_q   <= out_valid_d;
            out_product_q <= out_product_d;
            out_tag_q     <= out_tag_d;
            out_err_q     <= out_err_d;
        end
    end

    assign mult_start  = (state_q == ISSUE);
    assign mult_a      = a_q;
    assign mult_b      = b_q;
    assign out_valid   = out_valid_q;
    assign out_product = out_product_q;
    assign out_tag     = out_tag_q;
    assign out_err     = out_err_q;
    assign busy        = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_mult_issue_queue.sv
// Directed bench for mult_issue_queue with a behavioural multiplier model and
// a result scoreboard filled at push time.
module tb_mult_issue_queue;

    localparam int WIDTH   = 8;
    localparam int DEPTH   = 4;
    localparam int TAG_W   = 2;
    localparam int TIMEOUT = 15;

    typedef struct {
        logic [15:0] prod;
        logic [1:0]  tag;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_a = '0;
    logic [7:0]  in_b = '0;
    logic [1:0]  in_tag = '0;
    logic        mult_start;
    logic [7:0]  mult_a, mult_b;
    logic [15:0] mult_product;
    logic        mult_done;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_product;
    logic [1:0]  out_tag;
    logic        out_err;
    logic        busy;

    logic        model_done;
    logic [15:0] model_prod;
    logic        stray_done = 1'b0;
    logic [7:0]  pa, pb;
    int          lat = 9;
    int          cnt;

    int          tests = 0;
    int          fails = 0;
    exp_t        sb[$];

    always #5 clk = ~clk;

    mult_issue_queue #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .mult_start(mult_start), .mult_a(mult_a), .mult_b(mult_b),
        .mult_product(mult_product), .mult_done(mult_done),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_product(out_product), .out_tag(out_tag), .out_err(out_err),
        .busy(busy)
    );

    function automatic logic [15:0] smul(input logic [7:0] a, input logic [7:0] b);
        logic signed [15:0] x, y;
        x = {{8{a[7]}}, a};
        y = {{8{b[7]}}, b};
        return 16'(x * y);
    endfunction

    // Multiplier model: done lat cycles after start; lat == 0 means never.
    assign mult_done    = model_done | stray_done;
    assign mult_product = model_prod;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= 0;
            model_done <= 1'b0;
            model_prod <= '0;
            pa         <= '0;
            pb         <= '0;
        end else begin
            model_done <= 1'b0;
            if (mult_start) begin
                cnt <= 1;
                pa  <= mult_a;
                pb  <= mult_b;
            end else if (cnt != 0) begin
                if (lat != 0 && cnt == lat - 1) begin
                    model_done <= 1'b1;
                    model_prod <= smul(pa, pb);
                    cnt        <= 0;
                end else begin
                    cnt <= cnt + 1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic push_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] tag,
                           input logic [15:0] p, input logic err, output bit acc);
        exp_t e;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        acc      = (in_ready === 1'b1);
        tick();
        in_valid = 1'b0;
        if (acc) begin
            e.prod = p;
            e.tag  = tag;
            e.err  = err;
            sb.push_back(e);
        end
    endtask

    task automatic wait_start();
        int n = 0;
        while (mult_start !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("start_seen", 32'(mult_start), 32'd1);
    endtask

    task automatic get_result(input int hold, input bit chk_next);
        int          n = 0;
        exp_t        e;
        logic [15:0] p0;
        logic [1:0]  t0;
        out_ready = 1'b0;
        while (out_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("out_valid_seen", 32'(out_valid), 32'd1);
        if (out_valid !== 1'b1) return;
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        $display("[TB] result tag=%0d product=%h err=%b (exp tag=%0d product=%h err=%b)",
                 out_tag, out_product, out_err, e.tag, e.prod, e.err);
        chk("out_product", 32'(out_product), 32'(e.prod));
        chk("out_tag", 32'(out_tag), 32'(e.tag));
        chk("out_err", 32'(out_err), 32'(e.err));
        p0 = out_product;
        t0 = out_tag;
        for (int i = 0; i < hold; i++) begin
            tick();
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_product", 32'(out_product), 32'(p0));
            chk("hold_tag", 32'(out_tag), 32'(t0));
            chk("hold_no_start", 32'(mult_start), 32'd0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("valid_drop", 32'(out_valid), 32'd0);
        if (chk_next) chk("next_issue", 32'(mult_start), 32'd1);
    endtask

    task automatic measure_latency(input string name, input int exp_cycles);
        int n = 0;
        while (out_valid !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk(name, 32'(n), 32'(exp_cycles));
    endtask

    initial begin
        bit acc;
        int n_acc;

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mult_start", 32'(mult_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rel_in_ready", 32'(in_ready), 32'd1);

        // 1: basic op and issue latency
        push_op(8'd3, 8'd5, 2'd1, 16'h000F, 1'b0, acc);
        chk("t1_accept", 32'(acc), 32'd1);
        chk("t1_no_start_early", 32'(mult_start), 32'd0);
        tick();
        chk("t1_start", 32'(mult_start), 32'd1);
        chk("t1_mult_a", 32'(mult_a), 32'd3);
        chk("t1_mult_b", 32'(mult_b), 32'd5);
        tick();
        chk("t1_start_once", 32'(mult_start), 32'd0);
        get_result(0, 1'b0);

        // 2: signed operands
        push_op(8'hFD, 8'd5, 2'd2, 16'hFFF1, 1'b0, acc);
        push_op(8'h80, 8'h80, 2'd3, 16'h4000, 1'b0, acc);
        get_result(0, 1'b0);
        get_result(0, 1'b0);

        // 3: fill the FIFO back to back
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 5) chk("t3_ready_full", 32'(in_ready), 32'd0);
            push_op(8'(i * 7 - 10), 8'(i + 3), 2'(i), smul(8'(i * 7 - 10), 8'(i + 3)), 1'b0, acc);
            if (acc) n_acc++;
        end
        chk("t3_accepted", 32'(n_acc), 32'd5);
        for (int i = 0; i < 5; i++) get_result(0, 1'b0);

        // 4: backpressure on the result port
        push_op(8'd7, 8'hFE, 2'd2, 16'hFFF2, 1'b0, acc);
        push_op(8'd10, 8'd11, 2'd3, 16'h006E, 1'b0, acc);
        get_result(20, 1'b1);
        get_result(0, 1'b0);

        // 5: timeout, then a normal op behind it
        lat = 0;
        push_op(8'd9, 8'd9, 2'd1, 16'h0000, 1'b1, acc);
        push_op(8'hFF, 8'hFF, 2'd2, 16'h0001, 1'b0, acc);
        wait_start();
        measure_latency("t5_timeout_latency", TIMEOUT + 1);
        lat = WIDTH + 1;
        get_result(0, 1'b1);
        get_result(0, 1'b0);

        // 5b: done on the expiry cycle wins
        lat = TIMEOUT;
        push_op(8'hFB, 8'd6, 2'd0, 16'hFFE2, 1'b0, acc);
        wait_start();
        measure_latency("t5b_done_latency", TIMEOUT + 1);
        get_result(0, 1'b0);
        lat = WIDTH + 1;

        // 6: reset in the middle of WAIT
        push_op(8'd4, 8'd4, 2'd1, 16'h0010, 1'b0, acc);
        push_op(8'd2, 8'd2, 2'd2, 16'h0004, 1'b0, acc);
        wait_start();
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        chk("t6_in_ready", 32'(in_ready), 32'd0);
        chk("t6_mult_start", 32'(mult_start), 32'd0);
        chk("t6_mult_a", 32'(mult_a), 32'd0);
        chk("t6_mult_b", 32'(mult_b), 32'd0);
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_out_product", 32'(out_product), 32'd0);
        chk("t6_out_tag", 32'(out_tag), 32'd0);
        chk("t6_out_err", 32'(out_err), 32'd0);
        chk("t6_busy", 32'(busy), 32'd0);
        sb.delete();
        tick();
        rst_n = 1'b1;
        tick();
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        repeat (3) tick();
        chk("t6_stray_valid", 32'(out_valid), 32'd0);
        chk("t6_stray_busy", 32'(busy), 32'd0);
        chk("t6_stray_start", 32'(mult_start), 32'd0);
        chk("t6_ready_after", 32'(in_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
